// File: rtl/pipe_hazard_if.sv
// rtl/pipe_hazard_if.sv - ID/EX hazard bus between the pipeline datapath and the hazard controller
interface pipe_hazard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  ex_busy;
    logic                  ex_branch_taken;
    logic                  stall_if;
    logic                  stall_id;
    logic                  flush_id;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  ex_valid;
    logic                  mem_valid;
    logic                  wb_valid;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;

    // Datapath side: presents the ID instruction and EX status, consumes control.
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_mem_read, ex_busy, ex_branch_taken,
        input  stall_if, stall_id, flush_id, fwd_a_sel, fwd_b_sel,
               ex_valid, mem_valid, wb_valid, stall_cycles, flush_count
    );

    // Controller side.
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_mem_read, ex_busy, ex_branch_taken,
        output stall_if, stall_id, flush_id, fwd_a_sel, fwd_b_sel,
               ex_valid, mem_valid, wb_valid, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard, stall/flush and forwarding controller
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int FWD_ENABLE     = 1,
    parameter int CNT_W          = 16
) (
    input logic         clk,
    input logic         reset,
    pipe_hazard_if.slave bus
);
    localparam bit LOAD_FROM_WB_ONLY = (LOAD_USE_STALL == 2);
    localparam bit FWD_ON            = (FWD_ENABLE != 0);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } sb_t;

    sb_t              ex_q, mem_q, wb_q;
    logic [1:0]       fwd_a_q, fwd_b_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic       m_ex_a, m_ex_b, m_mem_a, m_mem_b;
    logic       load_hz, raw_hz, hz, taken, stall, issue;
    logic [1:0] fwd_a_nxt, fwd_b_nxt;

    // x0 is hardwired, so it never carries a dependency.
    function automatic logic src_match(input sb_t s, input logic [REG_ADDR_W-1:0] rs,
                                       input logic use_rs);
        return use_rs & s.valid & s.reg_write & (rs != '0) & (s.rd == rs);
    endfunction

    // Hazard detection, branch priority and next forwarding selects for the ID instruction.
    always_comb begin
        m_ex_a  = src_match(ex_q,  bus.id_rs1, bus.id_use_rs1);
        m_ex_b  = src_match(ex_q,  bus.id_rs2, bus.id_use_rs2);
        m_mem_a = src_match(mem_q, bus.id_rs1, bus.id_use_rs1);
        m_mem_b = src_match(mem_q, bus.id_rs2, bus.id_use_rs2);

        load_hz = ((m_ex_a | m_ex_b) & ex_q.mem_read)
                | (LOAD_FROM_WB_ONLY & (m_mem_a | m_mem_b) & mem_q.mem_read);
        // Without forwarding the consumer waits until the producer sits in WB,
        // where the register file's write-before-read bypass covers it.
        raw_hz  = !FWD_ON & (m_ex_a | m_ex_b | m_mem_a | m_mem_b);
        hz      = bus.id_valid & (load_hz | raw_hz);

        // A taken branch kills the ID instruction, so it overrides any hazard stall.
        taken   = !reset & bus.ex_branch_taken & !bus.ex_busy & ex_q.valid;
        stall   = !reset & (bus.ex_busy | (hz & !taken));
        issue   = bus.id_valid & !hz & !taken;

        // Nearest producer wins: EX/MEM result is younger than MEM/WB.
        fwd_a_nxt = 2'b00;
        fwd_b_nxt = 2'b00;
        if (FWD_ON) begin
            if (m_ex_a)       fwd_a_nxt = 2'b01;
            else if (m_mem_a) fwd_a_nxt = 2'b10;
            if (m_ex_b)       fwd_b_nxt = 2'b01;
            else if (m_mem_b) fwd_b_nxt = 2'b10;
        end
    end

    // Scoreboard advance; a busy EX keeps its instruction and selects and sends a bubble to MEM.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else if (bus.ex_busy) begin
            mem_q   <= '0;
            wb_q    <= mem_q;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            if (issue) begin
                ex_q    <= '{valid: 1'b1, rd: bus.id_rd, reg_write: bus.id_reg_write,
                             mem_read: bus.id_mem_read};
                fwd_a_q <= fwd_a_nxt;
                fwd_b_q <= fwd_b_nxt;
            end else begin
                ex_q    <= '0;
                fwd_a_q <= 2'b00;
                fwd_b_q <= 2'b00;
            end
        end
    end

    // Saturating performance counters for stall cycles and accepted taken branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (taken && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.stall_if     = stall;
    assign bus.stall_id     = stall;
    assign bus.flush_id     = taken;
    assign bus.fwd_a_sel    = fwd_a_q;
    assign bus.fwd_b_sel    = fwd_b_q;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.mem_valid    = mem_q.valid;
    assign bus.wb_valid     = wb_q.valid;
    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_count  = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized bench for pipe_hazard_ctrl against a distance-based pipeline model
module tb_pipe_hazard_ctrl;
    localparam int NCFG = 3;
    localparam int LUS_P [NCFG] = '{1, 2, 1};
    localparam int FWD_P [NCFG] = '{1, 1, 0};
    localparam int CW_P  [NCFG] = '{4, 16, 16};
    localparam int NCYC = 4000;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_busy, ex_branch_taken;

    logic [31:0] o_stall_if [NCFG];
    logic [31:0] o_stall_id [NCFG];
    logic [31:0] o_flush    [NCFG];
    logic [31:0] o_fa       [NCFG];
    logic [31:0] o_fb       [NCFG];
    logic [31:0] o_exv      [NCFG];
    logic [31:0] o_memv     [NCFG];
    logic [31:0] o_wbv      [NCFG];
    logic [31:0] o_sc       [NCFG];
    logic [31:0] o_fc       [NCFG];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        pipe_hazard_if #(.REG_ADDR_W(5), .CNT_W(CW_P[g])) bus ();

        assign bus.id_valid        = id_valid;
        assign bus.id_rs1          = id_rs1;
        assign bus.id_rs2          = id_rs2;
        assign bus.id_use_rs1      = id_use_rs1;
        assign bus.id_use_rs2      = id_use_rs2;
        assign bus.id_rd           = id_rd;
        assign bus.id_reg_write    = id_reg_write;
        assign bus.id_mem_read     = id_mem_read;
        assign bus.ex_busy         = ex_busy;
        assign bus.ex_branch_taken = ex_branch_taken;

        pipe_hazard_ctrl #(
            .REG_ADDR_W    (5),
            .LOAD_USE_STALL(LUS_P[g]),
            .FWD_ENABLE    (FWD_P[g]),
            .CNT_W         (CW_P[g])
        ) dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus)
        );

        assign o_stall_if[g] = 32'(bus.stall_if);
        assign o_stall_id[g] = 32'(bus.stall_id);
        assign o_flush[g]    = 32'(bus.flush_id);
        assign o_fa[g]       = 32'(bus.fwd_a_sel);
        assign o_fb[g]       = 32'(bus.fwd_b_sel);
        assign o_exv[g]      = 32'(bus.ex_valid);
        assign o_memv[g]     = 32'(bus.mem_valid);
        assign o_wbv[g]      = 32'(bus.wb_valid);
        assign o_sc[g]       = 32'(bus.stall_cycles);
        assign o_fc[g]       = 32'(bus.flush_count);
    end

    // Reference model: in-flight instructions by distance from ID (index 0 = one ahead, i.e. EX).
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
    } inst_t;

    inst_t m_pipe [NCFG][3];
    int    m_sa   [NCFG];
    int    m_sb   [NCFG];
    int    m_sc   [NCFG];
    int    m_fc   [NCFG];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Distance at which a producer's result becomes readable by the ID consumer.
    function automatic int ready_dist(input int c, input bit ld);
        if (FWD_P[c] == 0) return 3;
        return ld ? LUS_P[c] + 1 : 1;
    endfunction

    function automatic bit produces(input int c, input int d, input int rs, input bit use_rs);
        return use_rs && rs != 0 && m_pipe[c][d].v && m_pipe[c][d].rw && m_pipe[c][d].rd == rs;
    endfunction

    function automatic bit src_wait(input int c, input int rs, input bit use_rs);
        for (int d = 0; d < 2; d++)
            if (produces(c, d, rs, use_rs) && (d + 1) < ready_dist(c, m_pipe[c][d].ld))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int src_sel(input int c, input int rs, input bit use_rs);
        if (FWD_P[c] == 0) return 0;
        for (int d = 0; d < 2; d++)
            if (produces(c, d, rs, use_rs)) return d + 1;
        return 0;
    endfunction

    function automatic int sat_inc(input int v, input int w);
        int top;
        top = (1 << w) - 1;
        return (v < top) ? v + 1 : top;
    endfunction

    initial begin
        bit    h, tk, st, iss;
        inst_t nxt;

        reset = 1'b1;
        id_valid = 1'b0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        ex_busy = 1'b0; ex_branch_taken = 1'b0;
        for (int c = 0; c < NCFG; c++) begin
            for (int d = 0; d < 3; d++) m_pipe[c][d] = '{v: 0, rd: 0, rw: 0, ld: 0};
            m_sa[c] = 0; m_sb[c] = 0; m_sc[c] = 0; m_fc[c] = 0;
        end
        repeat (2) @(posedge clk);
        #1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            reset           = (cyc == 0) || ($urandom_range(0, 99) == 0);
            id_valid        = ($urandom_range(0, 9) < 8);
            id_rs1          = 5'($urandom_range(0, 7));
            id_rs2          = 5'($urandom_range(0, 7));
            id_rd           = 5'($urandom_range(0, 7));
            id_use_rs1      = ($urandom_range(0, 9) < 8);
            id_use_rs2      = ($urandom_range(0, 9) < 6);
            id_reg_write    = ($urandom_range(0, 9) < 8);
            id_mem_read     = ($urandom_range(0, 9) < 3);
            ex_busy         = ($urandom_range(0, 9) < 2);
            ex_branch_taken = ($urandom_range(0, 9) < 1);

            @(negedge clk);
            for (int c = 0; c < NCFG; c++) begin
                h  = id_valid && (src_wait(c, int'(id_rs1), id_use_rs1) ||
                                  src_wait(c, int'(id_rs2), id_use_rs2));
                tk = !reset && ex_branch_taken && !ex_busy && m_pipe[c][0].v;
                st = !reset && (ex_busy || (h && !tk));

                check_eq($sformatf("c%0d_stall_if", c),  o_stall_if[c], 32'(st));
                check_eq($sformatf("c%0d_stall_id", c),  o_stall_id[c], 32'(st));
                check_eq($sformatf("c%0d_flush_id", c),  o_flush[c],    32'(tk));
                check_eq($sformatf("c%0d_fwd_a", c),     o_fa[c],       32'(m_sa[c]));
                check_eq($sformatf("c%0d_fwd_b", c),     o_fb[c],       32'(m_sb[c]));
                check_eq($sformatf("c%0d_ex_valid", c),  o_exv[c],      32'(m_pipe[c][0].v));
                check_eq($sformatf("c%0d_mem_valid", c), o_memv[c],     32'(m_pipe[c][1].v));
                check_eq($sformatf("c%0d_wb_valid", c),  o_wbv[c],      32'(m_pipe[c][2].v));
                check_eq($sformatf("c%0d_stall_cnt", c), o_sc[c],       32'(m_sc[c]));
                check_eq($sformatf("c%0d_flush_cnt", c), o_fc[c],       32'(m_fc[c]));

                if (reset) begin
                    for (int d = 0; d < 3; d++) m_pipe[c][d].v = 1'b0;
                    m_sa[c] = 0; m_sb[c] = 0; m_sc[c] = 0; m_fc[c] = 0;
                end else begin
                    if (st) m_sc[c] = sat_inc(m_sc[c], CW_P[c]);
                    if (tk) m_fc[c] = sat_inc(m_fc[c], CW_P[c]);
                    m_pipe[c][2] = m_pipe[c][1];
                    if (ex_busy) begin
                        m_pipe[c][1].v = 1'b0;
                    end else begin
                        iss = id_valid && !h && !tk;
                        nxt = '{v: iss, rd: int'(id_rd), rw: id_reg_write, ld: id_mem_read};
                        m_sa[c] = iss ? src_sel(c, int'(id_rs1), id_use_rs1) : 0;
                        m_sb[c] = iss ? src_sel(c, int'(id_rs2), id_use_rs2) : 0;
                        m_pipe[c][1] = m_pipe[c][0];
                        m_pipe[c][0] = nxt;
                    end
                end
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
